// File: rtl/simplebus_ram_pkg.sv
// Shared definitions for the SimpleBus RAM slave: lane/index sizing helpers,
// read latency and the default response record.
// Optional feature macro: SIMPLEBUS_RAM_OUTREG_EN (adds a RAM output register, LAT = 2).
package simplebus_ram_pkg;

  function automatic int unsigned sb_lanes(input int unsigned dw);
    return dw / 8;
  endfunction

  // Number of low byte-offset address bits ignored by word addressing.
  function automatic int unsigned sb_off_width(input int unsigned dw);
    return (dw > 8) ? $clog2(dw / 8) : 0;
  endfunction

  function automatic int unsigned sb_idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned sb_read_lat();
`ifdef SIMPLEBUS_RAM_OUTREG_EN
    return 2;
`else
    return 1;
`endif
  endfunction

  // Default response record at the legacy 32-bit width; wider builds
  // declare their own record with the same field layout.
  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } sb_rsp_t;

endpackage

// File: rtl/simplebus_rsp_fifo.sv
// First-word-fall-through response FIFO. When empty, a pushed entry is
// visible on the output in the same cycle and is not stored if popped then.
module simplebus_rsp_fifo
  import simplebus_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = sb_rsp_t
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  T                           i_push_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output T                           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_empty;
  logic w_bypass;
  logic w_wr;
  logic w_rd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty  = (r_count == '0);
  assign o_valid  = !w_empty || i_push;
  assign w_bypass = w_empty && i_push && i_pop;
  assign w_wr     = i_push && !w_bypass;
  assign w_rd     = i_pop && !w_empty;
  assign o_count  = r_count;

  // Head entry, or the incoming entry when empty; zero when nothing is valid.
  always_comb begin
    o_data = '0;
    if (!w_empty)
      o_data = r_mem[r_rd_ptr];
    else if (i_push)
      o_data = i_push_data;
  end

  // Entry storage; contents need no reset since validity comes from the count.
  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd)
        r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  // A push into a full FIFO without a matching pop means the credit scheme broke.
  always_ff @(posedge i_clk) begin
    if (i_rst_n)
      assert (!(w_wr && !w_rd && (r_count == CW'(DEPTH))));
  end

endmodule

// File: rtl/simplebus_ram.sv
// Parametrised single-port SimpleBus RAM slave with byte-lane writes,
// credit-limited response FIFO and out-of-range read error reporting.
// Optional feature macro: SIMPLEBUS_RAM_OUTREG_EN (register stage after the
// RAM read port, read latency 2, requires RSP_FIFO_DEPTH >= 2).
module simplebus_ram
  import simplebus_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_DEPTH     = 16384,
  parameter int unsigned RSP_FIFO_DEPTH = 2
) (
  input  logic                    io_mainClk,
  input  logic                    resetCtrl_systemResetn,
  input  logic                    io_bus_cmd_valid,
  output logic                    io_bus_cmd_ready,
  input  logic                    io_bus_cmd_payload_write,
  input  logic [31:0]             io_bus_cmd_payload_address,
  input  logic [DATA_WIDTH-1:0]   io_bus_cmd_payload_data,
  input  logic [DATA_WIDTH/8-1:0] io_bus_cmd_payload_mask,
  output logic                    io_bus_rsp_valid,
  input  logic                    io_bus_rsp_ready,
  output logic [DATA_WIDTH-1:0]   io_bus_rsp_payload_data,
  output logic                    io_bus_rsp_payload_error
);

  localparam int unsigned LANES = sb_lanes(DATA_WIDTH);
  localparam int unsigned OFF   = sb_off_width(DATA_WIDTH);
  localparam int unsigned IW    = sb_idx_width(ADDR_DEPTH);
  localparam int unsigned LAT   = sb_read_lat();
  localparam int unsigned CW    = $clog2(RSP_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  error;
  } rsp_t;

  if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
    $error("simplebus_ram: DATA_WIDTH must be a multiple of 8, at least 8");
  end
  if (RSP_FIFO_DEPTH < LAT) begin : g_bad_depth
    $error("simplebus_ram: RSP_FIFO_DEPTH must cover the read latency");
  end

  logic                  w_cmd_fire;
  logic                  w_rd_fire;
  logic                  w_wr_fire;
  logic [31:0]           w_word;
  logic [IW-1:0]         w_idx;
  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_ram_q;
  rsp_t                  w_rd_rsp;
  rsp_t                  w_push_rsp;
  logic                  w_push;
  logic                  w_fifo_valid;
  rsp_t                  w_fifo_data;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_rsp_fire;

  logic                  r_rd_valid;
  logic                  r_rd_oor;
  logic [CW-1:0]         r_credits;

  // Address decode: the full word number must fit, so set high address bits
  // are out of range rather than aliasing onto a low word.
  assign w_word     = io_bus_cmd_payload_address >> OFF;
  assign w_idx      = w_word[IW-1:0];
  assign w_in_range = (w_word < 32'(ADDR_DEPTH));

  assign io_bus_cmd_ready = resetCtrl_systemResetn && (r_credits != '0);
  assign w_cmd_fire       = io_bus_cmd_valid && io_bus_cmd_ready;
  assign w_rd_fire        = w_cmd_fire && !io_bus_cmd_payload_write;
  assign w_wr_fire        = w_cmd_fire && io_bus_cmd_payload_write && w_in_range;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] r_mem [ADDR_DEPTH];
    logic [7:0] r_q;

    // Byte lane storage with synchronous read port.
    always_ff @(posedge io_mainClk) begin
      if (w_wr_fire && io_bus_cmd_payload_mask[l])
        r_mem[w_idx] <= io_bus_cmd_payload_data[8*l +: 8];
      if (w_rd_fire)
        r_q <= r_mem[w_idx];
    end

    assign w_ram_q[8*l +: 8] = r_q;
  end

  // Read pipeline tracking: which RAM outputs are live and whether they were out of range.
  always_ff @(posedge io_mainClk) begin
    if (!resetCtrl_systemResetn) begin
      r_rd_valid <= 1'b0;
      r_rd_oor   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire)
        r_rd_oor <= !w_in_range;
    end
  end

  assign w_rd_rsp.data  = r_rd_oor ? '0 : w_ram_q;
  assign w_rd_rsp.error = r_rd_oor;

`ifdef SIMPLEBUS_RAM_OUTREG_EN
  if (RSP_FIFO_DEPTH < 2) begin : g_bad_outreg_depth
    $error("simplebus_ram: output register stage needs RSP_FIFO_DEPTH >= 2");
  end

  logic r_s2_valid;
  rsp_t r_s2_rsp;

  // Output register stage between the RAM read port and the response FIFO.
  always_ff @(posedge io_mainClk) begin
    if (!resetCtrl_systemResetn) begin
      r_s2_valid <= 1'b0;
      r_s2_rsp   <= '0;
    end else begin
      r_s2_valid <= r_rd_valid;
      if (r_rd_valid)
        r_s2_rsp <= w_rd_rsp;
    end
  end

  assign w_push     = r_s2_valid;
  assign w_push_rsp = r_s2_rsp;
`else
  assign w_push     = r_rd_valid;
  assign w_push_rsp = w_rd_rsp;
`endif

  simplebus_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .T     (rsp_t)
  ) u_rsp_fifo (
    .i_clk       (io_mainClk),
    .i_rst_n     (resetCtrl_systemResetn),
    .i_push      (w_push),
    .i_push_data (w_push_rsp),
    .i_pop       (io_bus_rsp_ready),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_count     (w_fifo_count)
  );

  assign w_rsp_fire               = w_fifo_valid && io_bus_rsp_ready;
  assign io_bus_rsp_valid         = w_fifo_valid;
  assign io_bus_rsp_payload_data  = w_fifo_data.data;
  assign io_bus_rsp_payload_error = w_fifo_data.error;

  // Credit counter: one credit per outstanding read, returned when its response is taken.
  always_ff @(posedge io_mainClk) begin
    if (!resetCtrl_systemResetn) begin
      r_credits <= CW'(RSP_FIFO_DEPTH);
    end else begin
      case ({w_rd_fire, w_rsp_fire})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Stored responses plus remaining credits can never exceed the FIFO size.
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemResetn)
      assert ((32'(w_fifo_count) + 32'(r_credits)) <= RSP_FIFO_DEPTH);
  end

endmodule

// File: tb/tb_simplebus_ram.sv
// Directed self-checking bench for simplebus_ram (default build, 32-bit, depth 2 FIFO).
module tb_simplebus_ram;
  import simplebus_ram_pkg::*;

  localparam int unsigned LAT = sb_read_lat();

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;

  int n_assert = 0;
  int n_fail   = 0;

  simplebus_ram #(
    .DATA_WIDTH     (32),
    .ADDR_DEPTH     (16384),
    .RSP_FIFO_DEPTH (2)
  ) dut (
    .io_mainClk                 (clk),
    .resetCtrl_systemResetn     (rstn),
    .io_bus_cmd_valid           (cmd_valid),
    .io_bus_cmd_ready           (cmd_ready),
    .io_bus_cmd_payload_write   (cmd_write),
    .io_bus_cmd_payload_address (cmd_addr),
    .io_bus_cmd_payload_data    (cmd_data),
    .io_bus_cmd_payload_mask    (cmd_mask),
    .io_bus_rsp_valid           (rsp_valid),
    .io_bus_rsp_ready           (rsp_ready),
    .io_bus_rsp_payload_data    (rsp_data),
    .io_bus_rsp_payload_error   (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write fires on the following posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
  endtask

  // Single read with rsp_ready = 1 and an empty FIFO; response expected LAT cycles later.
  task automatic rd_check(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = a;
    check({tag, "_idle"}, 64'(rsp_valid), 64'(0));
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check({tag, "_valid"}, 64'(rsp_valid), 64'(1));
    check({tag, "_data"},  64'(rsp_data),  64'(exp_d));
    check({tag, "_error"}, 64'(rsp_error), 64'(exp_e));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_mask  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data",  64'(rsp_data),  64'(0));
    check("rst_rsp_error", 64'(rsp_error), 64'(0));
    rstn      = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Full-word write then immediate read
    wr(32'h100, 32'hDEADBEEF, 4'hF);
    rd_check("raw", 32'h100, 32'hDEADBEEF, 1'b0);

    // Byte-lane masked writes
    wr(32'h100, 32'h000000AA, 4'h1);
    wr(32'h100, 32'h0000BB00, 4'h2);
    rd_check("mask", 32'h100, 32'hDEADBBAA, 1'b0);
    wr(32'h100, 32'hFFFFFFFF, 4'h0);
    rd_check("mask0", 32'h100, 32'hDEADBBAA, 1'b0);

    // Backpressure: only two reads accepted while rsp_ready is low
    wr(32'h200, 32'h11111111, 4'hF);
    wr(32'h204, 32'h22222222, 4'hF);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h200;
    check("bp_ready1", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_addr  = 32'h204;
    check("bp_ready2", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_addr  = 32'h208;
    check("bp_ready3", 64'(cmd_ready), 64'(0));
    check("bp_valid_a", 64'(rsp_valid), 64'(1));
    check("bp_data_a",  64'(rsp_data),  64'(32'h11111111));
    @(negedge clk);
    check("bp_ready4", 64'(cmd_ready), 64'(0));
    check("bp_hold_a", 64'(rsp_data), 64'(32'h11111111));
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check("bp_ready_pop_cycle", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    check("bp_ready_after_pop", 64'(cmd_ready), 64'(1));
    check("bp_valid_b", 64'(rsp_valid), 64'(1));
    check("bp_data_b",  64'(rsp_data),  64'(32'h22222222));
    @(negedge clk);
    check("bp_drained", 64'(rsp_valid), 64'(0));

    // Out-of-range reads and dropped out-of-range writes
    wr(32'h0, 32'h5A5A5A5A, 4'hF);
    rd_check("oor_rd", 32'h0001_0000, 32'h0, 1'b1);
    rd_check("oor_hi", 32'h8000_0100, 32'h0, 1'b1);
    wr(32'h0001_0000, 32'hFFFFFFFF, 4'hF);
    check("oor_wr_no_rsp", 64'(rsp_valid), 64'(0));
    wr(32'h8000_0100, 32'hFFFFFFFF, 4'hF);
    rd_check("oor_keep0", 32'h0, 32'h5A5A5A5A, 1'b0);
    rd_check("oor_keep100", 32'h100, 32'hDEADBBAA, 1'b0);

    // Streaming reads at one response per cycle
    for (int k = 0; k < 16; k++)
      wr(32'h300 + 32'(4 * k), 32'hA5000000 + 32'(k), 4'hF);
    for (int i = 0; i < 16 + int'(LAT); i++) begin
      if (i < 16) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h300 + 32'(4 * i);
        check($sformatf("stream_ready_%0d", i), 64'(cmd_ready), 64'(1));
      end else begin
        cmd_valid = 1'b0;
      end
      if (i >= int'(LAT)) begin
        check($sformatf("stream_valid_%0d", i - int'(LAT)), 64'(rsp_valid), 64'(1));
        check($sformatf("stream_data_%0d", i - int'(LAT)), 64'(rsp_data),
              64'(32'hA5000000 + 32'(i - int'(LAT))));
      end
      @(negedge clk);
    end
    check("stream_done", 64'(rsp_valid), 64'(0));

    // Reset with two responses pending
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h100;
    @(negedge clk);
    cmd_addr  = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_pending_valid", 64'(rsp_valid), 64'(1));
    rstn = 1'b0;
    @(negedge clk);
    check("rst_flush_valid", 64'(rsp_valid), 64'(0));
    check("rst_flush_ready", 64'(cmd_ready), 64'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_addr  = 32'h100;
    check("rst_cred1", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_addr  = 32'h0;
    check("rst_cred2", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_cred_exhausted", 64'(cmd_ready), 64'(0));
    check("rst_keep_data_a", 64'(rsp_data), 64'(32'hDEADBBAA));
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_keep_data_b", 64'(rsp_data), 64'(32'h5A5A5A5A));
    @(negedge clk);
    check("rst_final_idle", 64'(rsp_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/simplebus_ram.md
# simplebus_ram

Parametrised single-port on-chip RAM slave for the SimpleBus cmd/rsp interface. Successor to the fixed 32-bit RAM slave: configurable data width and depth, response backpressure via `io_bus_rsp_ready` with a credit-limited response FIFO, out-of-range error reporting, and an optional output register stage. Sits behind the CPU/DMA SimpleBus decoder as main program/data memory.

## Interface
- `DATA_WIDTH`, default 32: bus data width, multiple of 8, min 8.
- `ADDR_DEPTH`, default 16384: number of words, power of 2.
- `RSP_FIFO_DEPTH`, default 2: response FIFO entries, ≥ read latency.
- `io_mainClk` in 1: sole clock, rising edge.
- `resetCtrl_systemResetn` in 1: reset, synchronous, active-low.
- `io_bus_cmd_valid` in 1: command valid.
- `io_bus_cmd_ready` out 1: command accepted when high with valid.
- `io_bus_cmd_payload_write` in 1: 1 = write, 0 = read.
- `io_bus_cmd_payload_address` in 32: byte address. Bits [log2(DATA_WIDTH/8)-1:0] are ignored.
- `io_bus_cmd_payload_data` in DATA_WIDTH: write data.
- `io_bus_cmd_payload_mask` in DATA_WIDTH/8: byte write enables.
- `io_bus_rsp_valid` out 1: read response valid.
- `io_bus_rsp_ready` in 1: consumer accepts response.
- `io_bus_rsp_payload_data` out DATA_WIDTH: read data.
- `io_bus_rsp_payload_error` out 1: out-of-range read.

## Operation
- Word index = `address >> log2(DATA_WIDTH/8)`. In range iff index < ADDR_DEPTH and all higher address bits are 0.
- Credit counter `credits`, range 0..RSP_FIFO_DEPTH, reset value RSP_FIFO_DEPTH.
  - Decrements on read fire.
  - Increments on rsp fire (`rsp_valid && rsp_ready`).
  - On both in the same cycle it is unchanged.
- `io_bus_cmd_ready = (credits != 0)`, for both reads and writes. It does not depend on payload.
- Write fire: each byte lane i with `mask[i]` is written. Mask 0 is a legal no-op. An out-of-range write is dropped silently and produces no response.
- Read fire: the RAM is read synchronously, and the result (data, error) is pushed into the response FIFO after the read latency.
  - Out-of-range read returns data 0, error 1.
  - In-range read returns error 0.
- The response FIFO is first-word-fall-through and in order. `rsp_payload_*` are held stable while `rsp_valid && !rsp_ready`.
- Credits guarantee the FIFO never overflows. Reaching an overflow condition is an assertion failure.
- Write followed by a read of the same address in the next cycle returns the new data.
- Read and write never fire together, because the port is single.
- Reset while active:
  - In-flight reads and FIFO contents are discarded.
  - credits are restored.
  - RAM contents are not cleared.

## Timing
- Reset values: `io_bus_cmd_ready` 1 after reset (0 while reset is asserted), `io_bus_rsp_valid` 0, `rsp_payload_data` 0, `rsp_payload_error` 0.
- Read latency LAT = 1, or 2 with the output register stage.
  - Read fired in cycle N with the FIFO empty gives `rsp_valid` in cycle N+LAT.
  - Back-to-back reads with `rsp_ready` = 1 sustain 1 response per cycle when RSP_FIFO_DEPTH ≥ LAT+1.
- With `rsp_ready` held 0, exactly RSP_FIFO_DEPTH reads are accepted, then `cmd_ready` drops. It rises in the cycle after the first rsp fire.
- Writes take 1 cycle and have no response.

## Configuration
- `SIMPLEBUS_RAM_OUTREG_EN` defined:
  - adds a register stage after the RAM read port, so LAT = 2;
  - RSP_FIFO_DEPTH must be ≥ 2 (elaboration check).
- Undefined: LAT = 1, and the RAM output feeds the FIFO directly.

## Structure
- Package `simplebus_ram_pkg`:
  - localparam functions for byte-lane count, word-index width and LAT;
  - a response struct typedef {data, error}.
- Sub-module `simplebus_rsp_fifo`: parametrised first-word-fall-through FIFO of response structs, with push/pop/count. The top level holds the RAM byte lanes, the address decode, the credit counter and the optional output register.

## Test plan
- Write 0xDEADBEEF with mask 0xF at 0x100, then read 0x100 -> `rsp_valid` at N+LAT, data 0xDEADBEEF, error 0.
- Write 0x000000AA with mask 0x1, then 0x0000BB00 with mask 0x2, to 0x100 (prior 0xDEADBEEF) -> read returns 0xDEADBBAA.
- With `rsp_ready` = 0, issue 4 reads (RSP_FIFO_DEPTH = 2) -> only 2 accepted, `cmd_ready` 0. Release `rsp_ready` -> responses in order, `cmd_ready` back 1 cycle after the first pop.
- Read at byte address ADDR_DEPTH*4 -> data 0, error 1. A write there leaves every in-range word unchanged.
- Stream 16 reads with `rsp_ready` = 1 -> 16 responses in consecutive cycles, `cmd_ready` constantly 1.
- Assert reset with 2 responses pending -> the next cycle `rsp_valid` is 0. After release, credits = RSP_FIFO_DEPTH and previously written data is still readable.
